// File: rtl/multicycle_adder.sv
// Serial adder: CHUNK bits of a+b+cin per cycle, LSB chunk first; result after WIDTH/CHUNK add cycles.
// Define MULTICYCLE_ADDER_SIGNED_OVF_EN to add the registered two's-complement overflow output ovf.
//
// state | meaning
// IDLE  | ready=1, waits for start, s holds the last completed result
// ADD   | one chunk of the latched operands added per edge
// DONE  | s carries the new result, valid pulses for one cycle
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             valid,
`ifdef MULTICYCLE_ADDER_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH:0]   s
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nx;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             last_chunk;
    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] chunk_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        valid    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nx = ADD;
                end
            end
            ADD: begin
                if (last_chunk) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                valid    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Chunk k is taken and written back by shifting, so CHUNK == WIDTH needs no special case.
    always_comb begin
        base       = 32'(k_q) * CHUNK;
        last_chunk = (k_q == KW'(N - 1));
        a_chunk    = CHUNK'(a_q >> base);
        b_chunk    = CHUNK'(b_q >> base);
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        chunk_mask = WIDTH'({CHUNK{1'b1}}) << base;
        sum_nx     = (sum_q & ~chunk_mask) | (WIDTH'(chunk_sum[CHUNK-1:0]) << base);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s       <= '0;
`ifdef MULTICYCLE_ADDER_SIGNED_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        k_q     <= '0;
                    end
                end
                ADD: begin
                    sum_q   <= sum_nx;
                    carry_q <= chunk_sum[CHUNK];
                    k_q     <= k_q + KW'(1);
                    if (last_chunk) begin
                        s <= {chunk_sum[CHUNK], sum_nx};
`ifdef MULTICYCLE_ADDER_SIGNED_OVF_EN
                        // Same-sign operands giving a different-sign sum equals carry-in(MSB) ^ carry-out(MSB).
                        ovf <= ~(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum_nx[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
